// File: rtl/rob_param.sv
// rob_param: parametrised reorder buffer with in-order retire, store handshake and mispredict flush.
// Allocates one entry per cycle, accepts N_WB writebacks per cycle, retires at most one entry per cycle.
module rob_param #(
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4,
    parameter int N_WB   = 2,
    parameter int HASH_W = 7
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  rdy_i,
    input  logic                  alloc_valid_i,
    input  logic [5:0]            alloc_op_i,
    input  logic [5:0]            alloc_rd_i,
    input  logic [31:0]           alloc_pc_pred_i,
    input  logic                  alloc_store_i,
    input  logic                  alloc_branch_i,
    output logic [IDX_W-1:0]      alloc_tag_o,
    output logic                  full_o,
    output logic                  empty_o,
    input  logic [N_WB-1:0]       wb_valid_i,
    input  logic [N_WB*IDX_W-1:0] wb_tag_i,
    input  logic [N_WB*32-1:0]    wb_value_i,
    input  logic [N_WB*32-1:0]    wb_addr_i,
    input  logic [N_WB*32-1:0]    wb_pc_real_i,
    input  logic [N_WB*32-1:0]    wb_pc_init_i,
    output logic                  commit_valid_o,
    output logic [IDX_W-1:0]      commit_tag_o,
    output logic [5:0]            commit_rd_o,
    output logic [31:0]           commit_value_o,
    output logic                  st_req_o,
    output logic [5:0]            st_op_o,
    output logic [31:0]           st_addr_o,
    output logic [31:0]           st_data_o,
    input  logic                  st_done_i,
    output logic                  flush_o,
    output logic [31:0]           redirect_pc_o,
    output logic                  bp_valid_o,
    output logic                  bp_taken_err_o,
    output logic [HASH_W-1:0]     bp_hash_o
);
    localparam int CW = IDX_W + 1;

    typedef enum logic {IDLE, ST_WAIT} state_t;

    state_t            state_q;
    logic [IDX_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DEPTH-1:0]  busy_q, ready_q, store_q, branch_q;
    logic [5:0]        op_q [DEPTH];
    logic [5:0]        rd_q [DEPTH];
    logic [31:0]       pc_pred_q [DEPTH];
    logic [31:0]       value_q [DEPTH];
    logic [31:0]       addr_q [DEPTH];
    logic [31:0]       pc_real_q [DEPTH];
    logic [31:0]       pc_init_q [DEPTH];

    logic                  commit_valid_q, st_req_q, flush_q, bp_valid_q, bp_taken_err_q;
    logic [IDX_W-1:0]      commit_tag_q;
    logic [5:0]            commit_rd_q, st_op_q;
    logic [31:0]           commit_value_q, st_addr_q, st_data_q, redirect_pc_q;
    logic [HASH_W-1:0]     bp_hash_q;

    logic [IDX_W-1:0]  wb_t [N_WB];
    logic [N_WB-1:0]   wb_hit;
    logic              can_ret, mis, commit_now, flush_now, st_start, st_fin, adv, alloc_en;

    always_comb begin
        wb_hit = '0;
        for (int p = 0; p < N_WB; p++) begin
            wb_t[p]   = wb_tag_i[p*IDX_W +: IDX_W];
            wb_hit[p] = rdy_i && wb_valid_i[p] && busy_q[wb_t[p]];
        end
    end

    assign full_o      = count_q == CW'(DEPTH);
    assign empty_o     = count_q == '0;
    assign alloc_tag_o = tail_q;

    assign can_ret    = rdy_i && state_q == IDLE && busy_q[head_q] && ready_q[head_q];
    assign mis        = pc_real_q[head_q] != pc_pred_q[head_q];
    assign commit_now = can_ret && !store_q[head_q];
    assign flush_now  = commit_now && mis;
    assign st_start   = can_ret && store_q[head_q];
    assign st_fin     = rdy_i && state_q == ST_WAIT && st_done_i;
    assign adv        = (commit_now && !mis) || st_fin;
    // full is judged on the start-of-cycle count, so a same-cycle retire never frees a slot early
    assign alloc_en   = rdy_i && alloc_valid_i && !full_o && !flush_now;

    assign head_d  = flush_now ? '0 : adv ? head_q + 1'b1 : head_q;
    assign tail_d  = flush_now ? '0 : alloc_en ? tail_q + 1'b1 : tail_q;
    assign count_d = flush_now ? '0 : count_q + CW'(alloc_en) - CW'(adv);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            busy_q         <= '0;
            ready_q        <= '0;
            commit_valid_q <= 1'b0;
            commit_tag_q   <= '0;
            commit_rd_q    <= '0;
            commit_value_q <= '0;
            st_req_q       <= 1'b0;
            st_op_q        <= '0;
            st_addr_q      <= '0;
            st_data_q      <= '0;
            flush_q        <= 1'b0;
            redirect_pc_q  <= '0;
            bp_valid_q     <= 1'b0;
            bp_taken_err_q <= 1'b0;
            bp_hash_q      <= '0;
        end else if (rdy_i) begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            commit_valid_q <= commit_now;
            flush_q        <= flush_now;
            bp_valid_q     <= commit_now && branch_q[head_q];
            if (commit_now) begin
                commit_tag_q   <= head_q;
                commit_rd_q    <= rd_q[head_q];
                commit_value_q <= value_q[head_q];
                bp_taken_err_q <= mis;
                bp_hash_q      <= pc_init_q[head_q][HASH_W-1:0];
            end
            if (flush_now)
                redirect_pc_q <= pc_real_q[head_q];
            if (flush_now) begin
                busy_q <= '0;
            end else begin
                if (alloc_en) begin
                    busy_q[tail_q]  <= 1'b1;
                    ready_q[tail_q] <= 1'b0;
                end
                for (int p = 0; p < N_WB; p++)
                    if (wb_hit[p])
                        ready_q[wb_t[p]] <= 1'b1;
                if (adv)
                    busy_q[head_q] <= 1'b0;
            end
            if (st_start) begin
                st_req_q  <= 1'b1;
                st_op_q   <= op_q[head_q];
                st_addr_q <= addr_q[head_q];
                st_data_q <= value_q[head_q];
                state_q   <= ST_WAIT;
            end else if (st_fin) begin
                st_req_q <= 1'b0;
                state_q  <= IDLE;
            end
        end
    end

    // Payload needs no reset: it is only read while the matching busy/ready bits are set
    always_ff @(posedge clk_i) begin
        if (rdy_i) begin
            if (alloc_en) begin
                op_q[tail_q]      <= alloc_op_i;
                rd_q[tail_q]      <= alloc_rd_i;
                pc_pred_q[tail_q] <= alloc_pc_pred_i;
                store_q[tail_q]   <= alloc_store_i;
                branch_q[tail_q]  <= alloc_branch_i;
            end
            for (int p = 0; p < N_WB; p++)
                if (wb_hit[p]) begin
                    value_q[wb_t[p]]   <= wb_value_i[p*32 +: 32];
                    addr_q[wb_t[p]]    <= wb_addr_i[p*32 +: 32];
                    pc_real_q[wb_t[p]] <= wb_pc_real_i[p*32 +: 32];
                    pc_init_q[wb_t[p]] <= wb_pc_init_i[p*32 +: 32];
                end
        end
    end

    assign commit_valid_o = commit_valid_q;
    assign commit_tag_o   = commit_tag_q;
    assign commit_rd_o    = commit_rd_q;
    assign commit_value_o = commit_value_q;
    assign st_req_o       = st_req_q;
    assign st_op_o        = st_op_q;
    assign st_addr_o      = st_addr_q;
    assign st_data_o      = st_data_q;
    assign flush_o        = flush_q;
    assign redirect_pc_o  = redirect_pc_q;
    assign bp_valid_o     = bp_valid_q;
    assign bp_taken_err_o = bp_taken_err_q;
    assign bp_hash_o      = bp_hash_q;
endmodule

// File: tb/tb_rob_param.sv
// tb_rob_param: directed self-checking bench for rob_param at DEPTH=4.
module tb_rob_param;
    localparam int IW = 2;
    localparam int NW = 2;

    logic          clk = 1'b0;
    logic          rst_n, rdy, alloc_valid, alloc_store, alloc_branch, st_done;
    logic [5:0]    alloc_op, alloc_rd;
    logic [31:0]   alloc_pc_pred;
    logic [IW-1:0] alloc_tag, commit_tag;
    logic          full, empty, commit_valid, st_req, flush, bp_valid, bp_taken_err;
    logic [NW-1:0]    wb_valid;
    logic [NW*IW-1:0] wb_tag;
    logic [NW*32-1:0] wb_value, wb_addr, wb_pc_real, wb_pc_init;
    logic [5:0]    commit_rd, st_op;
    logic [31:0]   commit_value, st_addr, st_data, redirect_pc;
    logic [6:0]    bp_hash;
    int checks = 0;
    int errors = 0;

    rob_param #(.DEPTH(4), .IDX_W(IW), .N_WB(NW), .HASH_W(7)) dut (
        .clk_i(clk), .rst_ni(rst_n), .rdy_i(rdy),
        .alloc_valid_i(alloc_valid), .alloc_op_i(alloc_op), .alloc_rd_i(alloc_rd),
        .alloc_pc_pred_i(alloc_pc_pred), .alloc_store_i(alloc_store), .alloc_branch_i(alloc_branch),
        .alloc_tag_o(alloc_tag), .full_o(full), .empty_o(empty),
        .wb_valid_i(wb_valid), .wb_tag_i(wb_tag), .wb_value_i(wb_value), .wb_addr_i(wb_addr),
        .wb_pc_real_i(wb_pc_real), .wb_pc_init_i(wb_pc_init),
        .commit_valid_o(commit_valid), .commit_tag_o(commit_tag), .commit_rd_o(commit_rd),
        .commit_value_o(commit_value), .st_req_o(st_req), .st_op_o(st_op), .st_addr_o(st_addr),
        .st_data_o(st_data), .st_done_i(st_done), .flush_o(flush), .redirect_pc_o(redirect_pc),
        .bp_valid_o(bp_valid), .bp_taken_err_o(bp_taken_err), .bp_hash_o(bp_hash)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rdy = 1'b1; alloc_valid = 1'b0; alloc_store = 1'b0; alloc_branch = 1'b0; st_done = 1'b0;
        alloc_op = '0; alloc_rd = '0; alloc_pc_pred = '0;
        wb_valid = '0; wb_tag = '0; wb_value = '0; wb_addr = '0; wb_pc_real = '0; wb_pc_init = '0;
    endtask

    task automatic reset_dut();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic do_alloc(input logic [5:0] op, input logic [5:0] rd, input logic [31:0] pp,
                            input logic st, input logic br);
        alloc_op = op; alloc_rd = rd; alloc_pc_pred = pp; alloc_store = st; alloc_branch = br;
        alloc_valid = 1'b1;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic set_wb(input int p, input logic [IW-1:0] tag, input logic [31:0] val,
                          input logic [31:0] addr, input logic [31:0] pcr, input logic [31:0] pci);
        wb_valid[p] = 1'b1;
        wb_tag[p*IW +: IW] = tag;
        wb_value[p*32 +: 32] = val;
        wb_addr[p*32 +: 32] = addr;
        wb_pc_real[p*32 +: 32] = pcr;
        wb_pc_init[p*32 +: 32] = pci;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0d want 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0d want 0", full); end
        checks++; if (alloc_tag !== 2'd0) begin errors++; $display("FAIL reset_tag: got %0d want 0", alloc_tag); end
        checks++; if ({commit_valid, st_req, flush, bp_valid} !== 4'b0) begin errors++; $display("FAIL reset_pulses: got %b want 0000", {commit_valid, st_req, flush, bp_valid}); end
        checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect: got %h want 0", redirect_pc); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_alloc_full();
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            checks++; if (alloc_tag !== 2'(i)) begin errors++; $display("FAIL full_tag%0d: got %0d want %0d", i, alloc_tag, i); end
            do_alloc(6'h1, 6'(i + 1), 32'h100 + 32'(4 * i), 1'b0, 1'b0);
        end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_set: got %0d want 1", full); end
        do_alloc(6'h1, 6'h3F, 32'h999, 1'b0, 1'b0);
        checks++; if (alloc_tag !== 2'd0) begin errors++; $display("FAIL full_refuse_tag: got %0d want 0", alloc_tag); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_hold: got %0d want 1", full); end
        set_wb(0, 2'd0, 32'h11, 32'h0, 32'h100, 32'hFC);
        tick();
        wb_valid = '0;
        checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL full_latency: got %0d want 0", commit_valid); end
        tick();
        checks++; if (commit_valid !== 1'b1 || commit_tag !== 2'd0) begin errors++; $display("FAIL full_commit: got v%0d t%0d want v1 t0", commit_valid, commit_tag); end
        checks++; if (commit_rd !== 6'd1 || commit_value !== 32'h11) begin errors++; $display("FAIL full_commit_data: got rd%0d %h want rd1 11", commit_rd, commit_value); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_clear: got %0d want 0", full); end
    endtask

    task automatic test_ooo_wb();
        reset_dut();
        for (int i = 0; i < 3; i++)
            do_alloc(6'h1, 6'(10 + i), 32'h200 + 32'(4 * i), 1'b0, 1'b0);
        set_wb(1, 2'd2, 32'h22, 32'h0, 32'h208, 32'h0); tick(); wb_valid = '0;
        set_wb(0, 2'd1, 32'h21, 32'h0, 32'h204, 32'h0); tick(); wb_valid = '0;
        set_wb(1, 2'd0, 32'h20, 32'h0, 32'h200, 32'h0); tick(); wb_valid = '0;
        checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL ooo_early: got %0d want 0", commit_valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (commit_valid !== 1'b1 || commit_tag !== 2'(i) || commit_value !== 32'h20 + 32'(i) || commit_rd !== 6'(10 + i))
                begin errors++; $display("FAIL ooo_commit%0d: got v%0d t%0d %h rd%0d want v1 t%0d %h rd%0d", i, commit_valid, commit_tag, commit_value, commit_rd, i, 32'h20 + i, 10 + i); end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ooo_empty: got %0d want 1", empty); end
        tick();
        checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL ooo_pulse: got %0d want 0", commit_valid); end
        do_alloc(6'h1, 6'd7, 32'h300, 1'b0, 1'b0);
        set_wb(0, 2'd3, 32'h1, 32'h0, 32'h300, 32'h0);
        set_wb(1, 2'd3, 32'h2, 32'h0, 32'h300, 32'h0);
        tick(); wb_valid = '0; tick();
        checks++; if (commit_valid !== 1'b1 || commit_tag !== 2'd3 || commit_value !== 32'h2) begin errors++; $display("FAIL ooo_port_prio: got v%0d t%0d %h want v1 t3 2", commit_valid, commit_tag, commit_value); end
    endtask

    task automatic test_store();
        reset_dut();
        do_alloc(6'h23, 6'd0, 32'h500, 1'b1, 1'b0);
        set_wb(0, 2'd0, 32'hAB, 32'h1000, 32'h0, 32'h0);
        do_alloc(6'h1, 6'd5, 32'h504, 1'b0, 1'b0);
        wb_valid = '0;
        set_wb(0, 2'd1, 32'h55, 32'h0, 32'h504, 32'h0);
        tick(); wb_valid = '0;
        checks++; if (st_req !== 1'b1 || st_addr !== 32'h1000 || st_data !== 32'hAB || st_op !== 6'h23)
            begin errors++; $display("FAIL st_req: got r%0d %h %h op%h want r1 1000 ab op23", st_req, st_addr, st_data, st_op); end
        checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL st_no_commit: got %0d want 0", commit_valid); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (st_req !== 1'b1 || st_addr !== 32'h1000 || commit_valid !== 1'b0) begin errors++; $display("FAIL st_hold%0d: got r%0d %h c%0d want r1 1000 c0", i, st_req, st_addr, commit_valid); end
        end
        st_done = 1'b1; tick(); st_done = 1'b0;
        checks++; if (st_req !== 1'b0 || commit_valid !== 1'b0 || empty !== 1'b0) begin errors++; $display("FAIL st_done: got r%0d c%0d e%0d want r0 c0 e0", st_req, commit_valid, empty); end
        tick();
        checks++; if (commit_valid !== 1'b1 || commit_tag !== 2'd1 || commit_value !== 32'h55 || empty !== 1'b1)
            begin errors++; $display("FAIL st_next: got v%0d t%0d %h e%0d want v1 t1 55 e1", commit_valid, commit_tag, commit_value, empty); end
    endtask

    task automatic test_mispredict();
        reset_dut();
        do_alloc(6'h2, 6'd1, 32'h40, 1'b0, 1'b1);
        do_alloc(6'h2, 6'd2, 32'h40, 1'b0, 1'b1);
        do_alloc(6'h1, 6'd3, 32'h999, 1'b0, 1'b0);
        set_wb(0, 2'd0, 32'hA0, 32'h0, 32'h40, 32'h10);
        set_wb(1, 2'd1, 32'hA1, 32'h0, 32'h80, 32'h1BC);
        tick(); wb_valid = '0; tick();
        checks++; if (commit_valid !== 1'b1 || bp_valid !== 1'b1 || bp_taken_err !== 1'b0 || flush !== 1'b0 || bp_hash !== 7'h10)
            begin errors++; $display("FAIL bp_ok: got c%0d bv%0d e%0d f%0d h%h want c1 bv1 e0 f0 h10", commit_valid, bp_valid, bp_taken_err, flush, bp_hash); end
        alloc_valid = 1'b1; alloc_pc_pred = 32'h777;
        tick();
        alloc_valid = 1'b0;
        checks++; if (flush !== 1'b1 || redirect_pc !== 32'h80) begin errors++; $display("FAIL mp_flush: got f%0d %h want f1 80", flush, redirect_pc); end
        checks++; if (bp_valid !== 1'b1 || bp_taken_err !== 1'b1 || bp_hash !== 7'h3C) begin errors++; $display("FAIL mp_bp: got v%0d e%0d h%h want v1 e1 h3c", bp_valid, bp_taken_err, bp_hash); end
        checks++; if (commit_valid !== 1'b1 || commit_tag !== 2'd1 || commit_value !== 32'hA1) begin errors++; $display("FAIL mp_commit: got v%0d t%0d %h want v1 t1 a1", commit_valid, commit_tag, commit_value); end
        checks++; if (empty !== 1'b1 || alloc_tag !== 2'd0) begin errors++; $display("FAIL mp_empty: got e%0d t%0d want e1 t0", empty, alloc_tag); end
        tick();
        checks++; if (flush !== 1'b0 || bp_valid !== 1'b0 || commit_valid !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL mp_after: got f%0d bv%0d c%0d e%0d want 0 0 0 1", flush, bp_valid, commit_valid, empty); end
    endtask

    task automatic test_wrap();
        reset_dut();
        for (int i = 0; i < 10; i++) begin
            checks++; if (alloc_tag !== 2'(i % 4)) begin errors++; $display("FAIL wrap_tag%0d: got %0d want %0d", i, alloc_tag, i % 4); end
            do_alloc(6'h1, 6'(i), 32'h1000 + 32'(4 * i), 1'b0, 1'b0);
            set_wb(i % 2, 2'(i % 4), 32'h500 + 32'(i), 32'h0, 32'h1000 + 32'(4 * i), 32'h0);
            tick(); wb_valid = '0; tick();
            checks++; if (commit_valid !== 1'b1 || commit_tag !== 2'(i % 4) || commit_value !== 32'h500 + 32'(i) || full !== 1'b0)
                begin errors++; $display("FAIL wrap_commit%0d: got v%0d t%0d %h f%0d want v1 t%0d %h f0", i, commit_valid, commit_tag, commit_value, full, i % 4, 32'h500 + i); end
        end
        for (int i = 0; i < 4; i++)
            do_alloc(6'h1, 6'd9, 32'h2000, 1'b0, 1'b0);
        checks++; if (full !== 1'b1 || alloc_tag !== 2'd2) begin errors++; $display("FAIL wrap_full: got f%0d t%0d want f1 t2", full, alloc_tag); end
        set_wb(0, 2'd2, 32'h62, 32'h0, 32'h2000, 32'h0);
        tick(); wb_valid = '0;
        alloc_valid = 1'b1;
        tick();
        alloc_valid = 1'b0;
        checks++; if (commit_valid !== 1'b1 || commit_tag !== 2'd2 || full !== 1'b0 || alloc_tag !== 2'd2)
            begin errors++; $display("FAIL wrap_refuse: got v%0d t%0d f%0d at%0d want v1 t2 f0 at2", commit_valid, commit_tag, full, alloc_tag); end
        set_wb(1, 2'd3, 32'h63, 32'h0, 32'h2000, 32'h0);
        tick(); wb_valid = '0;
        alloc_valid = 1'b1;
        tick();
        checks++; if (commit_valid !== 1'b1 || commit_tag !== 2'd3 || full !== 1'b0 || alloc_tag !== 2'd3)
            begin errors++; $display("FAIL wrap_both: got v%0d t%0d f%0d at%0d want v1 t3 f0 at3", commit_valid, commit_tag, full, alloc_tag); end
        tick();
        alloc_valid = 1'b0;
        checks++; if (full !== 1'b1 || alloc_tag !== 2'd0) begin errors++; $display("FAIL wrap_refill: got f%0d t%0d want f1 t0", full, alloc_tag); end
    endtask

    task automatic test_rdy_freeze();
        reset_dut();
        do_alloc(6'h23, 6'd0, 32'h0, 1'b1, 1'b0);
        set_wb(0, 2'd0, 32'hCD, 32'h2000, 32'h0, 32'h0);
        tick(); wb_valid = '0; tick();
        checks++; if (st_req !== 1'b1) begin errors++; $display("FAIL frz_start: got %0d want 1", st_req); end
        rdy = 1'b0; st_done = 1'b1; alloc_valid = 1'b1;
        set_wb(1, 2'd0, 32'hEE, 32'h3000, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (st_req !== 1'b1 || st_addr !== 32'h2000 || st_data !== 32'hCD || alloc_tag !== 2'd1 || empty !== 1'b0)
                begin errors++; $display("FAIL frz_hold%0d: got r%0d %h %h t%0d e%0d want r1 2000 cd t1 e0", i, st_req, st_addr, st_data, alloc_tag, empty); end
        end
        rdy = 1'b1; alloc_valid = 1'b0; wb_valid = '0;
        tick();
        st_done = 1'b0;
        checks++; if (st_req !== 1'b0 || empty !== 1'b1 || commit_valid !== 1'b0) begin errors++; $display("FAIL frz_resume: got r%0d e%0d c%0d want r0 e1 c0", st_req, empty, commit_valid); end
    endtask

    task automatic test_async_reset();
        reset_dut();
        do_alloc(6'h23, 6'd0, 32'h0, 1'b1, 1'b0);
        set_wb(0, 2'd0, 32'h1, 32'h40, 32'h0, 32'h0);
        tick(); wb_valid = '0; tick();
        checks++; if (st_req !== 1'b1) begin errors++; $display("FAIL ar_start: got %0d want 1", st_req); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (st_req !== 1'b0 || empty !== 1'b1 || alloc_tag !== 2'd0) begin errors++; $display("FAIL ar_drop: got r%0d e%0d t%0d want r0 e1 t0", st_req, empty, alloc_tag); end
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_alloc_full();
        test_ooo_wb();
        test_store();
        test_mispredict();
        test_wrap();
        test_rdy_freeze();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
